// File: rtl/timer_counter_if.sv
// Bus bundle between the system bridge and the timer: word-addressed register access plus the irq line.
interface timer_counter_if #(
  parameter int unsigned WIDTH = 32
);
  logic [1:0]       addr;
  logic             we;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] rd;
  logic             irq;

  modport master (output addr, output we, output wd, input rd, input irq);
  modport slave  (input addr, input we, input wd, output rd, output irq);
endinterface

// File: rtl/timer_counter.sv
// Memory-mapped down-counting timer: one-shot (level irq) or auto-reload (one-cycle irq pulse).
module timer_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic           clk,
  input  logic           reset,
  timer_counter_if.slave bus
);

  localparam logic [1:0] A_CTRL   = 2'd0;
  localparam logic [1:0] A_PRESET = 2'd1;
  localparam logic [1:0] A_COUNT  = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_CNT,
    S_INT
  } state_e;

  state_e           state_q, state_d;
  logic             en_q, en_d;
  logic [1:0]       mode_q, mode_d;
  logic             im_q, im_d;
  logic [WIDTH-1:0] preset_q, preset_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             flag_q, flag_d;

  logic             wr_ctrl_c;
  logic             wr_preset_c;
  logic             auto_reload_c;
  logic [WIDTH-1:0] rd_c;

  assign wr_ctrl_c     = bus.we && (bus.addr == A_CTRL);
  assign wr_preset_c   = bus.we && (bus.addr == A_PRESET);
  // Only MODE=1 reloads; MODE 2 and 3 fall back to one-shot.
  assign auto_reload_c = (mode_q == 2'd1);

  // Register file and counter state; reset aborts any count in progress.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      en_q     <= 1'b0;
      mode_q   <= 2'd0;
      im_q     <= 1'b0;
      preset_q <= '0;
      count_q  <= '0;
      flag_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      en_q     <= en_d;
      mode_q   <= mode_d;
      im_q     <= im_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      flag_q   <= flag_d;
    end
  end

  // Software writes first, then the FSM; the FSM's flag set overrides a write-clear,
  // while the INT-state EN clear yields to a concurrent CTRL write.
  always_comb begin
    state_d  = state_q;
    en_d     = en_q;
    mode_d   = mode_q;
    im_d     = im_q;
    preset_d = preset_q;
    count_d  = count_q;
    flag_d   = flag_q;

    if (wr_ctrl_c) begin
      en_d   = bus.wd[0];
      mode_d = bus.wd[2:1];
      im_d   = bus.wd[3];
    end
    if (wr_preset_c) begin
      preset_d = bus.wd;
    end
    if (wr_ctrl_c || wr_preset_c) begin
      flag_d = 1'b0;
    end

    unique case (state_q)
      S_IDLE: begin
        if (en_q) begin
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        count_d = preset_q;
        state_d = S_CNT;
      end
      S_CNT: begin
        if (!en_q) begin
          state_d = S_IDLE;
        end else if (count_q <= WIDTH'(1)) begin
          count_d = '0;
          flag_d  = 1'b1;
          state_d = S_INT;
        end else begin
          count_d = count_q - WIDTH'(1);
        end
      end
      S_INT: begin
        if (auto_reload_c) begin
          flag_d  = 1'b0;
          state_d = S_LOAD;
        end else begin
          if (!wr_ctrl_c) begin
            en_d = 1'b0;
          end
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Combinational read mux; unstored CTRL bits and the reserved word read as zero.
  always_comb begin
    rd_c = '0;
    unique case (bus.addr)
      A_CTRL:   rd_c = WIDTH'({im_q, mode_q, en_q});
      A_PRESET: rd_c = preset_q;
      A_COUNT:  rd_c = count_q;
      default:  rd_c = '0;
    endcase
  end

  assign bus.rd  = rd_c;
  assign bus.irq = flag_q & im_q;

endmodule
